// File: rtl/spi_slave_port.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave peripheral with an rxdata/txdata/status/control register map.
// Define SPI_SLAVE_EOP_EN to enable the end-of-packet value register and the EOP flag.
module spi_slave_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam logic [2:0]  ADDR_RXDATA  = 3'd0;
  localparam logic [2:0]  ADDR_TXDATA  = 3'd1;
  localparam logic [2:0]  ADDR_STATUS  = 3'd2;
  localparam logic [2:0]  ADDR_CONTROL = 3'd3;
  localparam logic [2:0]  ADDR_EOP     = 3'd6;
  localparam logic [15:0] CTL_MASK     = 16'h03D8;

  // ---------------- pin synchronizers and edge detection ----------------
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_bit, ss_q;
  logic frame_active;

  // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      // NOTE: SS_n stages reset to the deselected level so reset release cannot look like a frame start.
      ss_sync   <= '1;
      ss_q      <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      mosi_bit  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_sync[SYNC_STAGES];
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_sync[SYNC_STAGES];
      mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign frame_active = ~ss_q;
  assign MISO_oe      = ~ss_q;

  // ---------------- bus strobes: one action per access ----------------
  logic wr_seen, rd_seen, wr_pulse, rd_pulse;
  logic tx_wr, status_wr, ctl_wr, rx_rd;

  assign wr_pulse  = spi_select & ~write_n & ~wr_seen;
  assign rd_pulse  = spi_select & ~read_n & ~rd_seen;
  assign tx_wr     = wr_pulse & (mem_addr == ADDR_TXDATA);
  assign status_wr = wr_pulse & (mem_addr == ADDR_STATUS);
  assign ctl_wr    = wr_pulse & (mem_addr == ADDR_CONTROL);
  assign rx_rd     = rd_pulse & (mem_addr == ADDR_RXDATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_seen <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      wr_seen <= spi_select & ~write_n;
      rd_seen <= spi_select & ~read_n;
    end
  end

  // ---------------- frame engine ----------------
  logic [3:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte, rx_holding, tx_shift, tx_holding;
  logic       tx_primed, byte_done, tx_load;

  assign rx_byte   = {rx_shift, mosi_bit};
  assign byte_done = frame_active & sclk_rise & (bit_cnt == 4'd7);
  // A reload happens at frame start and after the last fall of each byte, so back-to-back bytes stream.
  assign tx_load   = ss_fall | (frame_active & sclk_fall & (bit_cnt == 4'd8));
  assign MISO      = tx_shift[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_holding <= '0;
    end else begin
      if (ss_fall || ss_rise) begin
        bit_cnt <= '0;
      end else if (frame_active) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 4'd1;
        end else if (sclk_fall && bit_cnt == 4'd8) begin
          bit_cnt <= '0;
        end
      end
      if (byte_done) rx_holding <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift   <= '0;
      tx_holding <= '0;
      tx_primed  <= 1'b0;
    end else begin
      if (tx_load)                         tx_shift <= tx_primed ? tx_holding : 8'h00;
      else if (frame_active && sclk_fall)  tx_shift <= {tx_shift[6:0], 1'b0};
      // Load and accept are exclusive: a primed load ignores the write, an unprimed load lets it through.
      if (tx_load && tx_primed) begin
        tx_primed <= 1'b0;
      end else if (tx_wr && !tx_primed) begin
        tx_holding <= data_from_cpu[7:0];
        tx_primed  <= 1'b1;
      end
    end
  end

  // ---------------- flags ----------------
  logic rrdy, roe, toe, eop;
  logic [15:0] eop_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrdy <= 1'b0;
      roe  <= 1'b0;
      toe  <= 1'b0;
    end else begin
      if (byte_done)                rrdy <= 1'b1;
      else if (rx_rd || status_wr)  rrdy <= 1'b0;
      if (byte_done && rrdy)        roe <= 1'b1;
      else if (status_wr)           roe <= 1'b0;
      if (tx_wr && tx_primed)       toe <= 1'b1;
      else if (status_wr)           toe <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic eop_wr, eop_hit;
  assign eop_wr  = wr_pulse & (mem_addr == ADDR_EOP);
  assign eop_hit = (byte_done && rx_byte == eop_value[7:0]) ||
                   (tx_wr && data_from_cpu[7:0] == eop_value[7:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eop_value <= '0;
      eop       <= 1'b0;
    end else begin
      if (eop_wr)         eop_value <= data_from_cpu;
      if (eop_hit)        eop <= 1'b1;
      else if (status_wr) eop <= 1'b0;
    end
  end
`else
  assign eop_value = '0;
  assign eop       = 1'b0;
`endif

  // ---------------- registers, read mux, interrupt ----------------
  logic [15:0] ctl, status_word, rd_mux;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctl <= '0;
    else if (ctl_wr) ctl <= data_from_cpu & CTL_MASK;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    status_word    = '0;
    status_word[3] = roe;
    status_word[4] = toe;
    status_word[5] = ~tx_primed & ss_q;
    status_word[6] = ~tx_primed;
    status_word[7] = rrdy;
    status_word[8] = roe | toe;
    status_word[9] = eop;
  end

  always_comb begin
    rd_mux = '0;
    case (mem_addr)
      ADDR_RXDATA:  rd_mux = {8'h00, rx_holding};
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = ctl;
      ADDR_EOP:     rd_mux = eop_value;
      default:      rd_mux = '0;
    endcase
  end

  // Control enables sit at the same bit positions as their status flags; TMT (bit 5) has no enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      data_to_cpu <= rd_mux;
      irq         <= |(status_word & ctl);
    end
  end

  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_primed;
  assign endofpacket   = eop;

endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port: a byte-level reference model queues expected responses,
// monitors compare register reads, status pins and MISO bytes as the DUT presents them.
module tb_spi_slave_port;

  localparam int S    = 2;   // synchronizer depth under test
  localparam int HALF = 10;  // clk cycles per SCLK phase (2.5 MHz master)

`ifdef SPI_SLAVE_EOP_EN
  localparam bit EOP_EN = 1'b1;
`else
  localparam bit EOP_EN = 1'b0;
`endif

  localparam int SRC_DATA = 0, SRC_IRQ = 1, SRC_OE = 2, SRC_MISO = 3,
                 SRC_RRDY = 4, SRC_TRDY = 5, SRC_EOP = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = 16'h0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata, endofpacket;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_oe;

  always #10 clk = ~clk;

  spi_slave_port #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .endofpacket(endofpacket),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  int          exp_src[$];
  logic [15:0] exp_val[$];
  string       exp_name[$];
  logic [7:0]  miso_q[$];
  event        mon_ev;

  task automatic expect_out(input int src, input logic [15:0] v, input string name);
    exp_src.push_back(src);
    exp_val.push_back(v);
    exp_name.push_back(name);
    -> mon_ev;
  endtask

  function automatic logic [15:0] sample(input int src);
    case (src)
      SRC_DATA: return data_to_cpu;
      SRC_IRQ:  return {15'd0, irq};
      SRC_OE:   return {15'd0, MISO_oe};
      SRC_MISO: return {15'd0, MISO};
      SRC_RRDY: return {15'd0, dataavailable};
      SRC_TRDY: return {15'd0, readyfordata};
      SRC_EOP:  return {15'd0, endofpacket};
      default:  return 16'hxxxx;
    endcase
  endfunction

  initial begin : out_monitor
    int src;
    logic [15:0] v;
    string nm;
    forever begin
      @(mon_ev);
      while (exp_src.size() > 0) begin
        src = exp_src.pop_front();
        v   = exp_val.pop_front();
        nm  = exp_name.pop_front();
        check(nm, sample(src), v);
      end
    end
  end

  // Master-side view of MISO: sampled on each SCLK rise, compared per completed byte.
  initial begin : miso_monitor
    logic [7:0] sh;
    int n;
    n = 0;
    sh = 8'h00;
    forever begin
      @(posedge SCLK or posedge SS_n);
      if (SS_n) begin
        n = 0;
      end else begin
        check("miso_oe during frame", {15'd0, MISO_oe}, 16'd1);
        sh = {sh[6:0], MISO};
        n++;
        if (n == 8) begin
          n = 0;
          if (miso_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso byte: got 0x%h, expected none queued", sh);
          end else begin
            check("miso byte", {8'h00, sh}, {8'h00, miso_q.pop_front()});
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit         m_primed, m_rrdy, m_roe, m_toe, m_eop;
  logic [7:0] m_hold, m_rx;
  logic [15:0] m_ctl, m_eopv;

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0000;
    s[3] = m_roe;
    s[4] = m_toe;
    s[5] = ~m_primed;  // bus accesses happen only while SS_n is high
    s[6] = ~m_primed;
    s[7] = m_rrdy;
    s[8] = m_roe | m_toe;
    s[9] = m_eop;
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_roe & m_ctl[3]) | (m_toe & m_ctl[4]) | (~m_primed & m_ctl[6]) |
           (m_rrdy & m_ctl[7]) | ((m_roe | m_toe) & m_ctl[8]) | (m_eop & m_ctl[9]);
  endfunction

  function automatic logic [7:0] m_load();
    logic [7:0] v;
    v = m_primed ? m_hold : 8'h00;
    m_primed = 1'b0;
    return v;
  endfunction

  // ---------------- bus driver and operations ----------------
  task automatic bus_write_hold(input logic [2:0] a, input logic [15:0] d, input int cycles);
    @(negedge clk);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    repeat (cycles) @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    @(negedge clk);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    expect_out(SRC_DATA, exp, name);
    spi_select = 1'b0; read_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic op_tx(input logic [7:0] d);
    bus_write_hold(3'd1, {8'($urandom), d}, 1);
    if (EOP_EN && d == m_eopv[7:0]) m_eop = 1'b1;
    if (!m_primed) begin m_hold = d; m_primed = 1'b1; end
    else m_toe = 1'b1;
  endtask

  task automatic op_status_clr();
    bus_write_hold(3'd2, 16'($urandom), 1);
    m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0; m_eop = 1'b0;
  endtask

  task automatic op_ctl(input logic [15:0] v);
    bus_write_hold(3'd3, v, 1);
    m_ctl = v & 16'h03D8;
  endtask

  task automatic op_eopv(input logic [15:0] v);
    bus_write_hold(3'd6, v, 1);
    if (EOP_EN) m_eopv = v;
  endtask

  task automatic op_rd_rx();
    bus_read(3'd0, {8'h00, m_rx}, "rxdata");
    m_rrdy = 1'b0;
  endtask

  task automatic op_rd_status();
    bus_read(3'd2, m_status(), "status");
  endtask

  task automatic op_rd_ctl();
    bus_read(3'd3, m_ctl, "control");
  endtask

  task automatic op_rd_eop();
    bus_read(3'd6, EOP_EN ? m_eopv : 16'h0000, "eop value");
  endtask

  task automatic op_rd_unused();
    logic [2:0] a;
    case ($urandom_range(0, 3))
      0:       a = 3'd1;
      1:       a = 3'd4;
      2:       a = 3'd5;
      default: a = 3'd7;
    endcase
    bus_read(a, 16'h0000, "unmapped read");
  endtask

  task automatic check_pins();
    expect_out(SRC_IRQ,  {15'd0, m_irq()},    "irq");
    expect_out(SRC_RRDY, {15'd0, m_rrdy},     "dataavailable");
    expect_out(SRC_TRDY, {15'd0, ~m_primed},  "readyfordata");
    expect_out(SRC_EOP,  {15'd0, m_eop},      "endofpacket");
    expect_out(SRC_OE,   16'd0,               "miso_oe idle");
  endtask

  // ---------------- SPI master ----------------
  logic [7:0] f_bytes[$];

  task automatic set_bytes1(input logic [7:0] b0);
    f_bytes.delete(); f_bytes.push_back(b0);
  endtask

  // abort_bits > 0: send that many clocks then deselect; coincide: rxdata read lands with RRDY set.
  task automatic spi_frame(input int abort_bits, input bit coincide);
    logic [7:0] ld;
    @(negedge clk);
    SS_n = 1'b0;
    ld = m_load();
    repeat (HALF) @(negedge clk);
    if (abort_bits > 0) begin
      for (int i = 0; i < abort_bits; i++) begin
        MOSI = 1'($urandom_range(0, 1));
        repeat (HALF) @(negedge clk);
        SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
        SCLK = 1'b0;
      end
    end else begin
      for (int b = 0; b < f_bytes.size(); b++) begin
        miso_q.push_back(ld);
        for (int i = 7; i >= 0; i--) begin
          MOSI = f_bytes[b][i];
          repeat (HALF) @(negedge clk);
          SCLK = 1'b1;
          if (coincide && b == f_bytes.size() - 1 && i == 0) begin
            // RRDY is set on the (S+2)th clk edge after the 8th rise; the read strobe acts on that same edge.
            repeat (S + 1) @(negedge clk);
            mem_addr = 3'd0; spi_select = 1'b1; read_n = 1'b0;
            @(negedge clk);
            spi_select = 1'b0; read_n = 1'b1;
            repeat (HALF - S - 2) @(negedge clk);
          end else begin
            repeat (HALF) @(negedge clk);
          end
          SCLK = 1'b0;
        end
        if (EOP_EN && f_bytes[b] == m_eopv[7:0]) m_eop = 1'b1;
        if (m_rrdy) m_roe = 1'b1;
        m_rrdy = 1'b1;
        m_rx = f_bytes[b];
        ld = m_load();
      end
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0;
    m_hold = 8'h00; m_rx = 8'h00; m_ctl = 16'h0000; m_eopv = 16'h0000;

    repeat (3) @(negedge clk);
    expect_out(SRC_DATA, 16'h0000, "reset data_to_cpu");
    expect_out(SRC_IRQ,  16'h0000, "reset irq");
    expect_out(SRC_MISO, 16'h0000, "reset miso");
    expect_out(SRC_OE,   16'h0000, "reset miso_oe");
    reset_n = 1'b1;
    repeat (2 * S + 4) @(negedge clk);
    check_pins();
    op_rd_status();
    op_rd_rx();
    op_rd_ctl();

    // single byte: tx 0xA5 out, 0x3C in
    op_tx(8'hA5);
    set_bytes1(8'h3C);
    spi_frame(0, 1'b0);
    op_rd_status();
    check_pins();
    op_rd_rx();

    // two bytes, no read between: overrun and interrupt
    op_status_clr();
    f_bytes.delete(); f_bytes.push_back(8'h11); f_bytes.push_back(8'h22);
    spi_frame(0, 1'b0);
    op_rd_status();
    op_rd_rx();
    op_ctl(16'h0008);
    check_pins();
    op_status_clr();
    check_pins();
    op_ctl(16'h0000);

    // tx overrun: second write dropped
    op_tx(8'h55);
    op_tx(8'h66);
    op_rd_status();
    check_pins();
    set_bytes1(8'($urandom));
    spi_frame(0, 1'b0);
    set_bytes1(8'($urandom));
    spi_frame(0, 1'b0);
    op_status_clr();

    // a write strobe held for several cycles acts once
    bus_write_hold(3'd1, 16'h00C3, 4);
    m_hold = 8'hC3; m_primed = 1'b1;
    if (EOP_EN && m_eopv[7:0] == 8'hC3) m_eop = 1'b1;
    op_rd_status();
    set_bytes1(8'h5A);
    spi_frame(0, 1'b0);
    op_rd_rx();

    // aborted frame, then a clean one
    op_status_clr();
    spi_frame(4, 1'b0);
    op_rd_status();
    check_pins();
    set_bytes1(8'h81);
    spi_frame(0, 1'b0);
    op_rd_status();
    op_rd_rx();

    // rxdata read coinciding with RRDY set
    op_status_clr();
    set_bytes1(8'hE7);
    spi_frame(0, 1'b1);
    op_rd_status();
    check_pins();
    op_rd_rx();

    // end-of-packet detection
    op_status_clr();
    op_eopv(16'h000D);
    op_rd_eop();
    set_bytes1(8'h0D);
    spi_frame(0, 1'b0);
    op_rd_status();
    check_pins();

    // randomized operation mix
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 9))
        0: op_tx(($urandom_range(0, 3) == 0) ? m_eopv[7:0] : 8'($urandom));
        1: begin
          f_bytes.delete();
          for (int k = 0; k < $urandom_range(1, 3); k++)
            f_bytes.push_back(($urandom_range(0, 3) == 0) ? m_eopv[7:0] : 8'($urandom));
          spi_frame(0, 1'b0);
        end
        2: spi_frame($urandom_range(1, 7), 1'b0);
        3: op_rd_rx();
        4: op_rd_status();
        5: op_status_clr();
        6: op_ctl(16'($urandom));
        7: op_rd_ctl();
        8: if ($urandom_range(0, 1) == 0) op_eopv({8'($urandom), 8'($urandom_range(0, 3))});
           else op_rd_eop();
        default: op_rd_unused();
      endcase
      check_pins();
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_src.size() != 0 || miso_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d register and %0d miso expectations left, required 0",
               exp_src.size(), miso_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
